tile_grid_tracker: RTL and testbench

Parametrised, pipelined successor to the fixed 64-pixel tile selector. It maps an object's pixel coordinate onto a configurable tile grid with power-of-two tile size, arbitrary origin and bounded extent. It outputs the aligned tile corner, tile column/row indices and an in-grid flag. It also detects tile-to-tile transitions and counts how many consecutive samples the object has stayed in one tile. It sits between the object movement logic (e.g. Bumpy) and the board/collision logic that consumes per-tile decisions.

---
 rtl/tile_grid_tracker.sv | 129 ++++++++++++
 tb/tb_tile_grid_tracker.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_grid_tracker.sv
// tile_grid_tracker: maps an object's pixel coordinate onto a power-of-two
// tile grid with configurable origin and extent. It reports the tile corner,
// the clamped column/row, an in-grid flag, tile transitions and a saturating
// dwell count. The block is a two-stage pipeline with full throughput.
module tile_grid_tracker #(
    parameter int COORD_W   = 11,
    parameter int TILE_LOG2 = 6,
    parameter int GRID_COLS = 10,
    parameter int GRID_ROWS = 7,
    parameter int ORIGIN_X  = 0,
    parameter int ORIGIN_Y  = 0,
    parameter int DWELL_W   = 8,
    localparam int COL_W    = (GRID_COLS > 2) ? $clog2(GRID_COLS) : 1,
    localparam int ROW_W    = (GRID_ROWS > 2) ? $clog2(GRID_ROWS) : 1
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               sampleValid,
    input  logic [COORD_W-1:0] objX,
    input  logic [COORD_W-1:0] objY,
    output logic               outValid,
    output logic [COORD_W-1:0] tileTopLeftX,
    output logic [COORD_W-1:0] tileTopLeftY,
    output logic [COL_W-1:0]   tileCol,
    output logic [ROW_W-1:0]   tileRow,
    output logic               inGrid,
    output logic               tileChanged,
    output logic [DWELL_W-1:0] dwellCount
);

    localparam int ID_W = 1 + COL_W + ROW_W;
    localparam logic signed [COORD_W:0] COLS_S = (COORD_W+1)'(GRID_COLS);
    localparam logic signed [COORD_W:0] ROWS_S = (COORD_W+1)'(GRID_ROWS);

    logic signed [COORD_W:0] relX, relY, rawCol, rawRow;
    logic [COL_W-1:0]        colD;
    logic [ROW_W-1:0]        rowD;
    logic                    inGridD;

    logic                    s1Valid;
    logic [COL_W-1:0]        s1Col;
    logic [ROW_W-1:0]        s1Row;
    logic                    s1In;

    logic [ID_W-1:0]         identD;
    logic [ID_W-1:0]         prevIdent;
    logic                    firstSeen;
    logic [COORD_W-1:0]      tlxD, tlyD;

    // Stage 1 datapath: origin-relative position, raw index and clamping.
    always_comb begin
        relX   = $signed({1'b0, objX}) - $signed((COORD_W+1)'(ORIGIN_X));
        relY   = $signed({1'b0, objY}) - $signed((COORD_W+1)'(ORIGIN_Y));
        rawCol = relX >>> TILE_LOG2;
        rawRow = relY >>> TILE_LOG2;
        // Negative raw indices fall through to the default of 0.
        colD = '0;
        if (rawCol >= COLS_S)
            colD = COL_W'(GRID_COLS - 1);
        else if (!relX[COORD_W])
            colD = rawCol[COL_W-1:0];
        rowD = '0;
        if (rawRow >= ROWS_S)
            rowD = ROW_W'(GRID_ROWS - 1);
        else if (!relY[COORD_W])
            rowD = rawRow[ROW_W-1:0];
        inGridD = !relX[COORD_W] && !relY[COORD_W] &&
                  (rawCol < COLS_S) && (rawRow < ROWS_S);
    end

    // Stage 1 register: capture resolved indices on each valid sample.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            s1Valid <= 1'b0;
            s1Col   <= '0;
            s1Row   <= '0;
            s1In    <= 1'b0;
        end else begin
            s1Valid <= sampleValid;
            if (sampleValid) begin
                s1Col <= colD;
                s1Row <= rowD;
                s1In  <= inGridD;
            end
        end
    end

    // Stage 2 datapath: tile corner and tile identity (all out-of-grid share one).
    always_comb begin
        tlxD   = (COORD_W'(s1Col) << TILE_LOG2) + COORD_W'(ORIGIN_X);
        tlyD   = (COORD_W'(s1Row) << TILE_LOG2) + COORD_W'(ORIGIN_Y);
        identD = s1In ? {1'b1, s1Col, s1Row} : '0;
    end

    // Stage 2 register: outputs, transition tracking and saturating dwell count.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            outValid     <= 1'b0;
            tileTopLeftX <= '0;
            tileTopLeftY <= '0;
            tileCol      <= '0;
            tileRow      <= '0;
            inGrid       <= 1'b0;
            tileChanged  <= 1'b0;
            dwellCount   <= '0;
            prevIdent    <= '0;
            firstSeen    <= 1'b0;
        end else begin
            outValid    <= s1Valid;
            tileChanged <= 1'b0;
            if (s1Valid) begin
                tileTopLeftX <= tlxD;
                tileTopLeftY <= tlyD;
                tileCol      <= s1Col;
                tileRow      <= s1Row;
                inGrid       <= s1In;
                firstSeen    <= 1'b1;
                prevIdent    <= identD;
                if (!firstSeen || identD != prevIdent) begin
                    tileChanged <= 1'b1;
                    dwellCount  <= '0;
                end else if (dwellCount != '1) begin
                    dwellCount <= dwellCount + DWELL_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_tile_grid_tracker.sv
// tb_tile_grid_tracker: drives two tile_grid_tracker instances (default grid
// and a shifted-origin 32-pixel grid) with shared stimulus, checks them every
// cycle against an arithmetic model and pins the model with hand values.
module tb_tile_grid_tracker;

    typedef struct packed {
        logic        v;
        logic [10:0] tlx;
        logic [10:0] tly;
        logic [3:0]  col;
        logic [2:0]  row;
        logic        in;
        logic        tc;
        logic [7:0]  dw;
    } res_t;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        sampleValid = 1'b0;
    logic [10:0] objX = '0;
    logic [10:0] objY = '0;

    logic        ov [2];
    logic [10:0] tlx [2];
    logic [10:0] tly [2];
    logic [3:0]  col [2];
    logic [2:0]  row [2];
    logic        ing [2];
    logic        tc [2];
    logic [7:0]  dw [2];

    res_t act [2];
    res_t exp_o [2];
    res_t obs [2][0:1023];
    int   obs_n [2];

    int checks = 0;
    int fails  = 0;

    int unsigned LG [2]  = '{6, 5};
    int          OXP [2] = '{0, 32};
    int          OYP [2] = '{0, 16};

    bit  p1v;
    int  p1x, p1y;
    bit  first_seen [2];
    int  prev_id [2];

    always #5 clk = ~clk;

    tile_grid_tracker u0 (
        .clk(clk), .resetN(resetN), .sampleValid(sampleValid),
        .objX(objX), .objY(objY), .outValid(ov[0]),
        .tileTopLeftX(tlx[0]), .tileTopLeftY(tly[0]),
        .tileCol(col[0]), .tileRow(row[0]), .inGrid(ing[0]),
        .tileChanged(tc[0]), .dwellCount(dw[0])
    );

    tile_grid_tracker #(.TILE_LOG2(5), .ORIGIN_X(32), .ORIGIN_Y(16)) u1 (
        .clk(clk), .resetN(resetN), .sampleValid(sampleValid),
        .objX(objX), .objY(objY), .outValid(ov[1]),
        .tileTopLeftX(tlx[1]), .tileTopLeftY(tly[1]),
        .tileCol(col[1]), .tileRow(row[1]), .inGrid(ing[1]),
        .tileChanged(tc[1]), .dwellCount(dw[1])
    );

    assign act[0] = {ov[0], tlx[0], tly[0], col[0], row[0], ing[0], tc[0], dw[0]};
    assign act[1] = {ov[1], tlx[1], tly[1], col[1], row[1], ing[1], tc[1], dw[1]};

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, a, e, $time);
        end
    endtask

    // Resolve a coordinate to clamped tile indices using floor division.
    function automatic void resolve(input int i, input int x, input int y,
                                    output int c, output int r, output bit inn);
        int rx, ry, rc, rr, tile;
        tile = 1 << LG[i];
        rx = x - OXP[i];
        ry = y - OYP[i];
        rc = (rx < 0) ? -1 : rx / tile;
        rr = (ry < 0) ? -1 : ry / tile;
        inn = (rx >= 0) && (ry >= 0) && (rc < 10) && (rr < 7);
        c = (rc < 0) ? 0 : ((rc > 9) ? 9 : rc);
        r = (rr < 0) ? 0 : ((rr > 6) ? 6 : rr);
    endfunction

    // Reference model: two-cycle delay, identity tracking, saturating dwell.
    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < 2; i++) begin
                exp_o[i]      <= '0;
                first_seen[i] <= 1'b0;
                prev_id[i]    <= 0;
            end
            p1v <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                res_t r;
                int   c, rw, id;
                bit   inn;
                r    = exp_o[i];
                r.v  = p1v;
                r.tc = 1'b0;
                if (p1v) begin
                    resolve(i, p1x, p1y, c, rw, inn);
                    id    = inn ? (c * 100 + rw) : -1;
                    r.col = 4'(c);
                    r.row = 3'(rw);
                    r.in  = inn;
                    r.tlx = 11'((c << LG[i]) + OXP[i]);
                    r.tly = 11'((rw << LG[i]) + OYP[i]);
                    if (!first_seen[i] || id != prev_id[i]) begin
                        r.tc = 1'b1;
                        r.dw = '0;
                    end else if (r.dw != 8'd255) begin
                        r.dw = r.dw + 8'd1;
                    end
                    first_seen[i] <= 1'b1;
                    prev_id[i]    <= id;
                end
                exp_o[i] <= r;
            end
            p1v <= sampleValid;
            if (sampleValid) begin
                p1x <= int'(objX);
                p1y <= int'(objY);
            end
        end
    end

    // Per-cycle compare of every output against the model, plus result log.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d.outValid", i),    32'(act[i].v),   32'(exp_o[i].v));
            chk($sformatf("u%0d.tileTopLeftX", i), 32'(act[i].tlx), 32'(exp_o[i].tlx));
            chk($sformatf("u%0d.tileTopLeftY", i), 32'(act[i].tly), 32'(exp_o[i].tly));
            chk($sformatf("u%0d.tileCol", i),     32'(act[i].col), 32'(exp_o[i].col));
            chk($sformatf("u%0d.tileRow", i),     32'(act[i].row), 32'(exp_o[i].row));
            chk($sformatf("u%0d.inGrid", i),      32'(act[i].in),  32'(exp_o[i].in));
            chk($sformatf("u%0d.tileChanged", i), 32'(act[i].tc),  32'(exp_o[i].tc));
            chk($sformatf("u%0d.dwellCount", i),  32'(act[i].dw),  32'(exp_o[i].dw));
            if (act[i].v === 1'b1 && obs_n[i] < 1024) begin
                obs[i][obs_n[i]] = act[i];
                obs_n[i]++;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int x, input int y);
        sampleValid = 1'b1;
        objX = 11'(x);
        objY = 11'(y);
        @(posedge clk);
        #1;
        sampleValid = 1'b0;
    endtask

    // Hand-computed expectation for one logged result.
    task automatic lit(input int i, input int k, input int c, input int r,
                       input int x, input int y, input int inn, input int t, input int d);
        string p;
        p = $sformatf("lit u%0d#%0d", i, k);
        chk({p, ".col"}, 32'(obs[i][k].col), c);
        chk({p, ".row"}, 32'(obs[i][k].row), r);
        chk({p, ".tlx"}, 32'(obs[i][k].tlx), x);
        chk({p, ".tly"}, 32'(obs[i][k].tly), y);
        chk({p, ".inGrid"}, 32'(obs[i][k].in), inn);
        chk({p, ".tileChanged"}, 32'(obs[i][k].tc), t);
        chk({p, ".dwell"}, 32'(obs[i][k].dw), d);
    endtask

    initial begin
        obs_n[0] = 0;
        obs_n[1] = 0;
        idle(3);
        resetN = 1'b1;
        idle(2);

        // Directed sequence on the default grid.
        send(100, 200);
        send(127, 255);
        send(64, 192);
        send(100, 200);
        send(128, 200);
        send(700, 470);
        send(650, 10);
        // Long dwell in one tile with sporadic gaps.
        for (int n = 0; n < 300; n++) begin
            send(10, 10);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        // Shifted-origin instance cases.
        send(20, 50);
        send(100, 50);
        send(10, 10);
        send(10, 10);
        idle(3);

        // Reset one cycle after a sample: that sample must be discarded.
        send(10, 10);
        resetN = 1'b0;
        idle(2);
        chk("rst.outValid", 32'(ov[0]), 0);
        chk("rst.tileCol", 32'(col[0]), 0);
        chk("rst.dwell", 32'(dw[0]), 0);
        chk("rst.tlx", 32'(tlx[0]), 0);
        resetN = 1'b1;
        idle(1);
        send(10, 10);
        idle(3);
        chk("rst.discard_count", 32'(obs_n[0]), 312);

        lit(0, 0, 1, 3, 64, 192, 1, 1, 0);
        lit(0, 1, 1, 3, 64, 192, 1, 0, 1);
        lit(0, 2, 1, 3, 64, 192, 1, 0, 2);
        lit(0, 3, 1, 3, 64, 192, 1, 0, 3);
        lit(0, 4, 2, 3, 128, 192, 1, 1, 0);
        lit(0, 5, 9, 6, 576, 384, 0, 1, 0);
        lit(0, 6, 9, 0, 576, 0, 0, 0, 1);
        lit(0, 7, 0, 0, 0, 0, 1, 1, 0);
        lit(0, 261, 0, 0, 0, 0, 1, 0, 254);
        lit(0, 262, 0, 0, 0, 0, 1, 0, 255);
        lit(0, 306, 0, 0, 0, 0, 1, 0, 255);
        lit(1, 307, 0, 1, 32, 48, 0, 0, 255);
        lit(1, 308, 2, 1, 96, 48, 1, 1, 0);
        lit(0, 309, 0, 0, 0, 0, 1, 1, 0);
        lit(0, 310, 0, 0, 0, 0, 1, 0, 1);
        lit(0, 311, 0, 0, 0, 0, 1, 1, 0);

        // Randomized traffic with gaps, repeats and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                resetN = 1'b0;
                idle($urandom_range(1, 2));
                resetN = 1'b1;
            end
            sampleValid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 2))
                0: begin
                    objX = 11'($urandom_range(0, 2047));
                    objY = 11'($urandom_range(0, 2047));
                end
                1: begin
                    objX = 11'($urandom_range(0, 700));
                    objY = 11'($urandom_range(0, 500));
                end
                default: ;
            endcase
            idle(1);
        end
        sampleValid = 1'b0;
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
